// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM fade sequencer.
// Imported by the top and the prescaler sub-module.
package pwm_seq_pkg;
  localparam int DEFAULT_DUTY_W = 8;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_BREATHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD
  } state_t;
endpackage

// File: rtl/pwm_tick_gen.sv
// Step-interval prescaler for the fade sequencer.
// Asserts tick on terminal count, then wraps to zero.
module pwm_tick_gen
  import pwm_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tick
);
  logic [W-1:0] count;

  assign tick = en && !clear && (count == limit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/pwm_fade_sequencer.sv
// Duty-cycle fade/breathe controller between the SPI
// register file and the PWM datapath.
module pwm_fade_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int DUTY_W     = DEFAULT_DUTY_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DUTY_W-1:0]     spi_duty,
  input  logic [DUTY_W-1:0]     cfg_target,
  input  logic [DUTY_W-1:0]     cfg_step,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_mode,
  input  logic                  start,
  input  logic                  abort,
  output logic [DUTY_W-1:0]     duty_out,
  output logic                  busy,
  output logic                  done
);
  state_t state;

  logic [DUTY_W-1:0]     cur;
  logic [DUTY_W-1:0]     origin;
  logic [DUTY_W-1:0]     sh_target;
  logic [DUTY_W-1:0]     sh_step;
  logic [PRESCALE_W-1:0] sh_prescale;
  logic                  sh_mode;
  logic                  dir;
  logic                  to_target;

  logic                  tick;
  logic                  launch;
  logic                  hold_now;
  logic [DUTY_W-1:0]     step_eff;
  logic [DUTY_W-1:0]     end_val;
  logic [DUTY_W-1:0]     next_cur;
  logic [DUTY_W:0]       sum;
  logic [DUTY_W:0]       diff;
  logic                  at_end;

  pwm_tick_gen #(
    .W(PRESCALE_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state != RAMP),
    .en   (state == RAMP),
    .limit(sh_prescale),
    .tick (tick)
  );

  assign launch   = start && (state != RAMP);
  assign hold_now = (duty_out == cfg_target)
                 && (cfg_mode == MODE_ONESHOT);
  assign step_eff = (cfg_step == '0)
                  ? DUTY_W'(1) : cfg_step;

  // Wider arithmetic so a step past either rail
  // is seen and clamped to the end value.
  always_comb begin
    end_val = to_target ? sh_target : origin;
    sum     = {1'b0, cur} + {1'b0, sh_step};
    diff    = {1'b0, cur} - {1'b0, sh_step};
    if (dir) begin
      at_end = (sum >= {1'b0, end_val});
    end else begin
      at_end = diff[DUTY_W]
            || (diff <= {1'b0, end_val});
    end
    if (at_end) begin
      next_cur = end_val;
    end else if (dir) begin
      next_cur = sum[DUTY_W-1:0];
    end else begin
      next_cur = diff[DUTY_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      duty_out    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cur         <= '0;
      origin      <= '0;
      sh_target   <= '0;
      sh_step     <= '0;
      sh_prescale <= '0;
      sh_mode     <= MODE_ONESHOT;
      dir         <= 1'b1;
      to_target   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        duty_out <= spi_duty;
      end else if (launch) begin
        sh_target   <= cfg_target;
        sh_step     <= step_eff;
        sh_prescale <= cfg_prescale;
        sh_mode     <= cfg_mode;
        origin      <= duty_out;
        cur         <= duty_out;
        dir         <= (cfg_target >= duty_out);
        to_target   <= 1'b1;
        if (hold_now) begin
          state <= HOLD;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= RAMP;
          busy  <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: duty_out <= spi_duty;
          RAMP: begin
            if (tick) begin
              cur      <= next_cur;
              duty_out <= next_cur;
              if (at_end) begin
                if (sh_mode == MODE_BREATHE) begin
                  dir       <= ~dir;
                  to_target <= ~to_target;
                end else begin
                  state <= HOLD;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end
          end
          HOLD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer.
// Inputs change 1ns after posedge; outputs checked there.
module tb_pwm_fade_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  spi_duty = '0;
  logic [7:0]  cfg_target = '0;
  logic [7:0]  cfg_step = '0;
  logic [15:0] cfg_prescale = '0;
  logic        cfg_mode = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  duty_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int passed = 0;

  pwm_fade_sequencer #(
    .PRESCALE_W(16),
    .DUTY_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_duty    (spi_duty),
    .cfg_target  (cfg_target),
    .cfg_step    (cfg_step),
    .cfg_prescale(cfg_prescale),
    .cfg_mode    (cfg_mode),
    .start       (start),
    .abort       (abort),
    .duty_out    (duty_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [7:0] t, input logic [7:0] s,
                     input logic [15:0] p, input logic m);
    cfg_target   = t;
    cfg_step     = s;
    cfg_prescale = p;
    cfg_mode     = m;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    spi_duty = 8'h5A;
    cyc(2);
    checks++;
    if (duty_out !== 8'h00)
      $display("FAIL reset duty: got %h want 00", duty_out);
    else passed++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset flags: got busy=%b done=%b want 0 0", busy, done);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_passthrough;
    spi_duty = 8'h40;
    cyc();
    checks++;
    if (duty_out !== 8'h40 || busy !== 1'b0)
      $display("FAIL passthrough: got %h busy=%b want 40 busy=0", duty_out, busy);
    else passed++;
  endtask

  task automatic test_oneshot_up;
    spi_duty = 8'h00;
    cyc();
    cfg(8'h0A, 8'd5, 16'd0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (duty_out !== 8'h00 || busy !== 1'b1)
      $display("FAIL up launch: got %h busy=%b want 00 busy=1", duty_out, busy);
    else passed++;
    cyc();
    checks++;
    if (duty_out !== 8'h05 || done !== 1'b0)
      $display("FAIL up step1: got %h done=%b want 05 done=0", duty_out, done);
    else passed++;
    spi_duty = 8'h77;
    cyc();
    checks++;
    if (duty_out !== 8'h0A || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL up end: got %h done=%b busy=%b want 0a 1 0", duty_out, done, busy);
    else passed++;
    cyc();
    checks++;
    if (duty_out !== 8'h0A || done !== 1'b0)
      $display("FAIL up hold: got %h done=%b want 0a done=0", duty_out, done);
    else passed++;
  endtask

  task automatic test_hold_restart;
    cfg(8'h0A, 8'd5, 16'd0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || duty_out !== 8'h0A)
      $display("FAIL hold restart: got done=%b busy=%b %h want 1 0 0a", done, busy, duty_out);
    else passed++;
    cyc();
    checks++;
    if (done !== 1'b0)
      $display("FAIL hold restart pulse: got done=%b want 0", done);
    else passed++;
    abort = 1'b1;
    spi_duty = 8'h33;
    cyc();
    abort = 1'b0;
    checks++;
    if (duty_out !== 8'h33 || busy !== 1'b0)
      $display("FAIL hold abort: got %h busy=%b want 33 busy=0", duty_out, busy);
    else passed++;
  endtask

  task automatic test_ramp_down;
    logic [7:0] exp_seq [4] = '{8'hBE, 8'h7E, 8'h3E, 8'h03};
    logic [7:0] prev;
    spi_duty = 8'hFE;
    cyc();
    cfg(8'h03, 8'h40, 16'd3, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cfg(8'h80, 8'h01, 16'd0, 1'b1);
    prev = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) start = 1'b1;
      cyc(3);
      start = 1'b0;
      checks++;
      if (duty_out !== prev || busy !== 1'b1)
        $display("FAIL down wait %0d: got %h busy=%b want %h busy=1", i, duty_out, busy, prev);
      else passed++;
      cyc();
      checks++;
      if (duty_out !== exp_seq[i])
        $display("FAIL down step %0d: got %h want %h", i, duty_out, exp_seq[i]);
      else passed++;
      prev = exp_seq[i];
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL down done: got done=%b busy=%b want 1 0", done, busy);
    else passed++;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic test_saturate_up;
    spi_duty = 8'hF0;
    cyc();
    cfg(8'hFF, 8'h20, 16'd0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if (duty_out !== 8'hFF || done !== 1'b1)
      $display("FAIL sat up: got %h done=%b want ff done=1", duty_out, done);
    else passed++;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic test_step_zero;
    spi_duty = 8'h05;
    cyc();
    cfg(8'h07, 8'h00, 16'd0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if (duty_out !== 8'h06)
      $display("FAIL step0 first: got %h want 06", duty_out);
    else passed++;
    cyc();
    checks++;
    if (duty_out !== 8'h07 || done !== 1'b1)
      $display("FAIL step0 end: got %h done=%b want 07 done=1", duty_out, done);
    else passed++;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic test_breathe;
    logic [7:0] exp_seq [6] = '{8'h18, 8'h20, 8'h18, 8'h10, 8'h18, 8'h20};
    logic [7:0] prev;
    spi_duty = 8'h10;
    cyc();
    cfg(8'h20, 8'd8, 16'd1, 1'b1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    prev = 8'h10;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if (duty_out !== prev || done !== 1'b0)
        $display("FAIL breathe wait %0d: got %h done=%b want %h 0", i, duty_out, done, prev);
      else passed++;
      cyc();
      checks++;
      if (duty_out !== exp_seq[i] || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL breathe step %0d: got %h busy=%b done=%b want %h 1 0", i, duty_out, busy, done, exp_seq[i]);
      else passed++;
      prev = exp_seq[i];
    end
    abort = 1'b1;
    spi_duty = 8'h55;
    cyc();
    abort = 1'b0;
    checks++;
    if (duty_out !== 8'h55 || busy !== 1'b0)
      $display("FAIL breathe abort: got %h busy=%b want 55 busy=0", duty_out, busy);
    else passed++;
  endtask

  task automatic test_abort_collision;
    spi_duty = 8'h00;
    cyc();
    cfg(8'hFF, 8'd1, 16'd0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(2);
    checks++;
    if (duty_out !== 8'h02 || busy !== 1'b1)
      $display("FAIL collide pre: got %h busy=%b want 02 busy=1", duty_out, busy);
    else passed++;
    abort = 1'b1;
    start = 1'b1;
    spi_duty = 8'h21;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (duty_out !== 8'h21 || busy !== 1'b0)
      $display("FAIL collide: got %h busy=%b want 21 busy=0", duty_out, busy);
    else passed++;
    spi_duty = 8'h22;
    cyc();
    checks++;
    if (duty_out !== 8'h22 || busy !== 1'b0)
      $display("FAIL collide idle: got %h busy=%b want 22 busy=0", duty_out, busy);
    else passed++;
  endtask

  task automatic test_rst_mid_ramp;
    spi_duty = 8'h30;
    cyc();
    cfg(8'hF0, 8'd4, 16'd0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (duty_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst mid: got %h busy=%b done=%b want 00 0 0", duty_out, busy, done);
    else passed++;
    spi_duty = 8'h09;
    cyc();
    checks++;
    if (duty_out !== 8'h09 || busy !== 1'b0)
      $display("FAIL rst idle: got %h busy=%b want 09 busy=0", duty_out, busy);
    else passed++;
  endtask

  initial begin
    cyc();
    test_reset();
    test_passthrough();
    test_oneshot_up();
    test_hold_restart();
    test_ramp_down();
    test_saturate_up();
    test_step_zero();
    test_breathe();
    test_abort_collision();
    test_rst_mid_ramp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
